// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
// RISC-V base-ISA instruction decode stage with registered outputs and a
// 2-entry skid buffer (output register + one skid register). It accepts one
// instruction per cycle over a valid/ready handshake. It splits the word into
// register indices, opcode and function fields. It builds a single immediate,
// sign-extended to XLEN. Unsupported encodings are flagged as illegal.
//
// Parameters
//   XLEN          datapath width (32 or 64); width of the PC and immediate
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   flush         synchronous flush; drops every held instruction
//   in_valid      upstream instruction valid
//   in_ready      stage can accept (registered)
//   in_instr      32-bit instruction word
//   in_pc         instruction address
//   out_valid     decoded bundle valid
//   out_ready     downstream accepts
//   out_pc        passed-through PC
//   out_opcode    instr[6:0]
//   out_rd/rs1/rs2 register indices; 0 when the format does not use them
//   out_funct3    instr[14:12]; 0 for U/J/illegal
//   out_funct7    instr[31:25]; R format only
//   out_imm       sign-extended immediate; 0 for R/illegal
//   out_fmt       0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
//   out_illegal   unsupported encoding
// ---------------------------------------------------------------------------
module id_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } bundle_t;

  // -------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // -------------------------------------------------------------------------
  logic [2:0]         w_fmt;
  logic signed [31:0] w_imm_i;
  logic signed [31:0] w_imm_s;
  logic signed [31:0] w_imm_b;
  logic signed [31:0] w_imm_u;
  logic signed [31:0] w_imm_j;
  bundle_t            w_dec;

  always_comb begin
    // Every legal opcode ends in 2'b11, so an exact 7-bit match also rejects
    // compressed / reserved low-bit encodings.
    case (in_instr[6:0])
      7'b0110011:                        w_fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111:            w_fmt = FMT_I;
      7'b0100011:                        w_fmt = FMT_S;
      7'b1100011:                        w_fmt = FMT_B;
      7'b0110111, 7'b0010111:            w_fmt = FMT_U;
      7'b1101111:                        w_fmt = FMT_J;
      default:                           w_fmt = FMT_ILL;
    endcase
  end

  // Each immediate is first assembled as a signed 32-bit value; the XLEN cast
  // below then sign-extends it (a no-op when XLEN=32).
  assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
  assign w_imm_u = {in_instr[31:12], 12'b0};
  assign w_imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

  always_comb begin
    w_dec         = '0;
    w_dec.pc      = in_pc;
    w_dec.opcode  = in_instr[6:0];
    w_dec.fmt     = w_fmt;
    w_dec.illegal = (w_fmt == FMT_ILL);
    case (w_fmt)
      FMT_R: begin
        w_dec.rd     = in_instr[11:7];
        w_dec.rs1    = in_instr[19:15];
        w_dec.rs2    = in_instr[24:20];
        w_dec.funct3 = in_instr[14:12];
        w_dec.funct7 = in_instr[31:25];
      end
      FMT_I: begin
        w_dec.rd     = in_instr[11:7];
        w_dec.rs1    = in_instr[19:15];
        w_dec.funct3 = in_instr[14:12];
        w_dec.imm    = XLEN'(w_imm_i);
      end
      FMT_S: begin
        w_dec.rs1    = in_instr[19:15];
        w_dec.rs2    = in_instr[24:20];
        w_dec.funct3 = in_instr[14:12];
        w_dec.imm    = XLEN'(w_imm_s);
      end
      FMT_B: begin
        w_dec.rs1    = in_instr[19:15];
        w_dec.rs2    = in_instr[24:20];
        w_dec.funct3 = in_instr[14:12];
        w_dec.imm    = XLEN'(w_imm_b);
      end
      FMT_U: begin
        w_dec.rd     = in_instr[11:7];
        w_dec.imm    = XLEN'(w_imm_u);
      end
      FMT_J: begin
        w_dec.rd     = in_instr[11:7];
        w_dec.imm    = XLEN'(w_imm_j);
      end
      default: ; // illegal: fields and immediate stay 0
    endcase
  end

  // -------------------------------------------------------------------------
  // Output register (OR) + skid register (SK)
  // -------------------------------------------------------------------------
  bundle_t r_or;
  bundle_t r_sk;
  logic    r_or_valid;
  logic    r_sk_valid;
  logic    r_in_ready;

  bundle_t w_or_nxt;
  bundle_t w_sk_nxt;
  logic    w_or_valid_nxt;
  logic    w_sk_valid_nxt;
  logic    w_accept;
  logic    w_or_free;

  assign w_accept  = in_valid && r_in_ready && !flush;
  // OR can take a new bundle when it is empty or being drained this cycle.
  assign w_or_free = !r_or_valid || out_ready;

  always_comb begin
    w_or_nxt       = r_or;
    w_sk_nxt       = r_sk;
    w_or_valid_nxt = r_or_valid;
    w_sk_valid_nxt = r_sk_valid;
    if (flush) begin
      w_or_valid_nxt = 1'b0;
      w_sk_valid_nxt = 1'b0;
    end else if (w_or_free) begin
      if (r_sk_valid) begin
        // in_ready is low whenever SK holds data, so no accept can collide.
        w_or_nxt       = r_sk;
        w_or_valid_nxt = 1'b1;
        w_sk_valid_nxt = 1'b0;
      end else if (w_accept) begin
        w_or_nxt       = w_dec;
        w_or_valid_nxt = 1'b1;
      end else begin
        w_or_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      // OR is stalled: park the new bundle in SK.
      w_sk_nxt       = w_dec;
      w_sk_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_or       <= '0;
      r_sk       <= '0;
      r_or_valid <= 1'b0;
      r_sk_valid <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_or       <= w_or_nxt;
      r_sk       <= w_sk_nxt;
      r_or_valid <= w_or_valid_nxt;
      r_sk_valid <= w_sk_valid_nxt;
      // Registered copy of !SK.valid so in_ready has no combinational path.
      r_in_ready <= !w_sk_valid_nxt;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_or_valid;
  assign out_pc      = r_or.pc;
  assign out_opcode  = r_or.opcode;
  assign out_rd      = r_or.rd;
  assign out_rs1     = r_or.rs1;
  assign out_rs2     = r_or.rs2;
  assign out_funct3  = r_or.funct3;
  assign out_funct7  = r_or.funct7;
  assign out_imm     = r_or.imm;
  assign out_fmt     = r_or.fmt;
  assign out_illegal = r_or.illegal;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] pc64 = '0;

  // 32-bit instance
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3, out_fmt;
  // 64-bit instance (same stimulus)
  logic        in_ready_w, out_valid_w, out_illegal_w;
  logic [63:0] out_pc_w, out_imm_w;
  logic [6:0]  out_opcode_w, out_funct7_w;
  logic [4:0]  out_rd_w, out_rs1_w, out_rs2_w;
  logic [2:0]  out_funct3_w, out_fmt_w;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(pc64[31:0]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  id_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_w),
    .in_instr(in_instr), .in_pc(pc64),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .out_pc(out_pc_w), .out_opcode(out_opcode_w),
    .out_rd(out_rd_w), .out_rs1(out_rs1_w), .out_rs2(out_rs2_w),
    .out_funct3(out_funct3_w), .out_funct7(out_funct7_w),
    .out_imm(out_imm_w), .out_fmt(out_fmt_w), .out_illegal(out_illegal_w)
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } item_t;

  item_t q[$];   // bundles held by the stage, oldest first
  int n_checks = 0;
  int n_err = 0;

  // Reference decode written straight from the format rules.
  function automatic vec_t ref_decode(logic [31:0] i);
    vec_t v;
    v.instr = i; v.rd = '0; v.rs1 = '0; v.rs2 = '0; v.f3 = '0; v.f7 = '0; v.imm = '0;
    case (i[6:0])
      7'h33:                             v.fmt = 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: v.fmt = 3'd1;
      7'h23:                             v.fmt = 3'd2;
      7'h63:                             v.fmt = 3'd3;
      7'h37, 7'h17:                      v.fmt = 3'd4;
      7'h6F:                             v.fmt = 3'd5;
      default:                           v.fmt = 3'd7;
    endcase
    v.ill = (v.fmt == 3'd7);
    if (v.fmt inside {3'd0, 3'd1, 3'd4, 3'd5}) v.rd  = i[11:7];
    if (v.fmt inside {3'd0, 3'd1, 3'd2, 3'd3}) v.rs1 = i[19:15];
    if (v.fmt inside {3'd0, 3'd2, 3'd3})       v.rs2 = i[24:20];
    if (v.fmt <= 3'd3)                         v.f3  = i[14:12];
    if (v.fmt == 3'd0)                         v.f7  = i[31:25];
    case (v.fmt)
      3'd1: v.imm = 64'($signed(i[31:20]));
      3'd2: v.imm = 64'($signed({i[31:25], i[11:7]}));
      3'd3: v.imm = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      3'd4: v.imm = 64'($signed({i[31:12], 12'b0}));
      3'd5: v.imm = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default: v.imm = '0;
    endcase
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare both instances against the model queue.
  task automatic check_model();
    vec_t v;
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid_64", out_valid_w, q.size() > 0);
    chk("in_ready_64", in_ready_w, q.size() < 2);
    if (q.size() > 0) begin
      v = ref_decode(q[0].instr);
      chk("pc", out_pc, q[0].pc[31:0]);
      chk("opcode", out_opcode, v.instr[6:0]);
      chk("rd", out_rd, v.rd);
      chk("rs1", out_rs1, v.rs1);
      chk("rs2", out_rs2, v.rs2);
      chk("funct3", out_funct3, v.f3);
      chk("funct7", out_funct7, v.f7);
      chk("imm", out_imm, v.imm[31:0]);
      chk("fmt", out_fmt, v.fmt);
      chk("illegal", out_illegal, v.ill);
      chk("pc_64", out_pc_w, q[0].pc);
      chk("imm_64", out_imm_w, v.imm);
      chk("fmt_64", out_fmt_w, v.fmt);
      chk("rd_64", out_rd_w, v.rd);
    end
  endtask

  // One clock: update the model from the pre-edge inputs, then check.
  task automatic cycle();
    bit    acc, pop;
    item_t it;
    acc = in_valid && (q.size() < 2) && !flush;
    pop = (q.size() > 0) && out_ready;
    it.pc = pc64;
    it.instr = in_instr;
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (pop) begin
        $display("xfer pc=%h instr=%h", q[0].pc, q[0].instr);
        void'(q.pop_front());
      end
      if (acc) q.push_back(it);
    end
    #1;
    check_model();
  endtask

  task automatic present(logic [31:0] instr, logic [63:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    pc64 = pc;
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_fmt"}, out_fmt, 0);
    chk({tag, "_imm"}, out_imm, 0);
    chk({tag, "_pc"}, out_pc, 0);
    chk({tag, "_out_valid_64"}, out_valid_w, 0);
    chk({tag, "_in_ready_64"}, in_ready_w, 1);
  endtask

  logic [6:0] legal_ops[11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F,
                                7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

  initial begin
    vec_t vecs[10];
    vecs[0] = '{32'hFFF10093, 3'd1, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[1] = '{32'h00512423, 3'd2, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 64'h0000_0000_0000_0008, 1'b0};
    vecs[2] = '{32'hFE208EE3, 3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vecs[3] = '{32'h001000EF, 3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'h0000_0000_0000_0800, 1'b0};
    vecs[4] = '{32'h800001B7, 3'd4, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[5] = '{32'h00000000, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'h0, 1'b1};
    vecs[6] = '{32'h402081B3, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 64'h0, 1'b0};
    vecs[7] = '{32'h00001117, 3'd4, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 64'h0000_0000_0000_1000, 1'b0};
    vecs[8] = '{32'h00000012, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'h0, 1'b1};
    vecs[9] = '{32'hFFFFF0FF, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'h0, 1'b1};

    // ---- reset ----
    #1 rst_n = 1'b0;
    #2 check_reset_state("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // ---- table-driven vectors, streamed back to back ----
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      present(vecs[k].instr, 64'h1000 + 64'(k) * 4);
      cycle();
      chk("tbl_valid", out_valid, 1);
      chk("tbl_fmt", out_fmt, vecs[k].fmt);
      chk("tbl_rd", out_rd, vecs[k].rd);
      chk("tbl_rs1", out_rs1, vecs[k].rs1);
      chk("tbl_rs2", out_rs2, vecs[k].rs2);
      chk("tbl_funct3", out_funct3, vecs[k].f3);
      chk("tbl_funct7", out_funct7, vecs[k].f7);
      chk("tbl_imm", out_imm, vecs[k].imm[31:0]);
      chk("tbl_imm_64", out_imm_w, vecs[k].imm);
      chk("tbl_illegal", out_illegal, vecs[k].ill);
      chk("tbl_opcode", out_opcode, vecs[k].instr[6:0]);
      chk("tbl_pc", out_pc, 32'h1000 + 32'(k) * 4);
    end
    in_valid = 1'b0;
    cycle();

    // ---- back-pressure: A, B accepted, C stalled, then A B C in order ----
    out_ready = 1'b0;
    present(32'h00100093, 64'hA0);  cycle();
    present(32'h00200113, 64'hB0);  cycle();
    chk("bp_in_ready_low", in_ready, 0);
    present(32'h00300193, 64'hC0);  cycle();
    chk("bp_hold_A", out_pc, 32'hA0);
    out_ready = 1'b1;               cycle();
    chk("bp_out_B", out_pc, 32'hB0);
    chk("bp_valid_B", out_valid, 1);
    cycle();
    chk("bp_out_C", out_pc, 32'hC0);
    chk("bp_valid_C", out_valid, 1);
    in_valid = 1'b0;                cycle();
    chk("bp_empty", out_valid, 0);

    // ---- flush with both registers full ----
    out_ready = 1'b0;
    present(32'h00400213, 64'hD0);  cycle();
    present(32'h00500293, 64'hE0);  cycle();
    present(32'h00600313, 64'hF0);
    flush = 1'b1;                   cycle();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      cycle();
      chk("flush_nothing_appears", out_valid, 0);
    end

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 600; n++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[6:0] = legal_ops[$urandom_range(0, 10)];
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      in_instr  = w;
      pc64      = {$urandom, $urandom};
      cycle();
    end
    flush = 1'b0;

    // ---- reset asserted mid-stream ----
    out_ready = 1'b0;
    present(32'h00700393, 64'h100); cycle();
    present(32'h00800413, 64'h104); cycle();
    #2 rst_n = 1'b0;
    #1 check_reset_state("midreset");
    q.delete();
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();
    chk("post_reset_idle", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Pipelined, parametrised RISC-V instruction-decode stage. Takes a fetched instruction word and its PC over a valid/ready handshake and splits it into register indices, opcode and function fields. It also builds a single immediate, fully assembled and sign-extended to XLEN for every base-ISA format, and flags illegal encodings. It sits between the fetch and execute stages, registers its outputs, and uses a 2-entry skid buffer so it can sustain one instruction per cycle under back-pressure.

## Interface
- XLEN, 32: datapath width (32 or 64); sets the immediate and PC width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush; drops all held instructions.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; driven from a register only.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts.
- out_pc  out  XLEN  passed-through PC.
- out_opcode  out  7  instr[6:0].
- out_rd, out_rs1, out_rs2  out  5 each  register indices; 0 when the format does not use the field.
- out_funct3  out  3  instr[14:12]; 0 for U and J formats.
- out_funct7  out  7  instr[31:25]; R format only, else 0.
- out_imm  out  XLEN  sign-extended immediate; 0 for R format.
- out_fmt  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- out_illegal  out  1  unsupported encoding.

## Operation
- **Opcode map**
  - R: 0110011.
  - I: 0010011, 0000011, 1100111, 1110011, 0001111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
- **Illegal encodings:** any other opcode, or instr[1:0]≠11. These give fmt=7, out_illegal=1, and all field and immediate outputs 0. out_opcode and out_pc are still passed through.
- **Immediates,** each sign-extended from instr[31] to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- **Field usage by format:**
  - rd: R, I, U, J.
  - rs1: R, I, S, B.
  - rs2: R, S, B.
- **Decode logic:** combinational on in_instr; the result is captured into the output register on acceptance (in_valid && in_ready).
- **Storage:** output register (OR) plus one skid register (SK), each with its own valid bit.
  - Accept while OR is empty, or OR is being drained this cycle: the bundle goes to OR.
  - Accept while OR is valid and out_ready=0: the bundle goes to SK.
  - OR drains with SK valid: SK moves to OR and SK empties.
  - in_ready = !SK.valid.
- **Ordering:** strict FIFO. Bundles are never duplicated or dropped except by flush.
- **Flush:** next edge clears OR.valid and SK.valid. Any instruction presented in the same cycle is dropped, even if in_ready=1. Flush has priority over every other event.

## Timing
- **Reset:** while rst_n=0, all outputs are 0 except in_ready=1 and out_fmt=0. This takes effect immediately (asynchronous) and clears the stage mid-operation.
- **Latency:** accept at edge N gives out_valid=1 after edge N, i.e. 1 cycle.
- **Throughput:** 1 per cycle while out_ready=1.
- **Stall:** with out_ready held low, at most 2 bundles are accepted. in_ready falls the cycle after the second acceptance.
- **Output stability:** while out_valid && !out_ready, all out_* hold stable.
- **Simultaneous drain and accept with SK valid:** cannot occur, because in_ready=0.
- **Simultaneous drain and accept with SK empty:** the new bundle goes to OR with no bubble.
- **Flush recovery:** after flush, out_valid=0 and in_ready=1 on the next cycle.

## Test plan
- **I format:** 0xFFF10093 (addi x1,x2,-1) → one cycle later out_valid=1, fmt=1, rd=1, rs1=2, rs2=0, funct3=0, imm=0xFFFFFFFF.
- **S and B formats:**
  - 0x00512423 (sw x5,8(x2)) → fmt=2, rs1=2, rs2=5, rd=0, imm=8.
  - 0xFE208EE3 (beq x1,x2,-4) → fmt=3, imm=0xFFFFFFFC.
- **J and U formats:**
  - 0x001000EF (jal x1,2048) → fmt=5, rd=1, imm=0x00000800.
  - With XLEN=64, 0x800001B7 (lui x3,0x80000) → fmt=4, rd=3, imm=0xFFFFFFFF80000000.
- **Back-pressure:** stream A, B, C on consecutive cycles with out_ready=0.
  - A and B are accepted; in_ready=0 on C's cycle.
  - Raise out_ready: outputs A, B, C in order on consecutive cycles with no gaps.
- **Flush with both registers full:** flush=1 with in_valid=1 → next cycle out_valid=0 and in_ready=1; the flushed-cycle instruction never appears.
- **Illegal and reset:** 0x00000000 → out_illegal=1, fmt=7, imm=0. Asserting rst_n=0 mid-stream immediately forces out_valid=0 and in_ready=1.
